dpram_port_arbiter: RTL and testbench
=====================================

// Module: dpram_port_arbiter
// PURPOSE
//  Shares one port of a single-clock dpram between two requesters, e.g. CPU
//  and vector generator, using round-robin req/gnt arbitration.
//  Returns read data with a valid strobe to the requester that issued it.
//  After reset it runs an optional clear sequence that writes zero to every
//  RAM word, because the RAM array has no reset. Sits between the requesters
//  and the dpram address/data/wren/q pins of one port.
// PARAMETERS
//  ADDR_WIDTH      15  RAM address width; matches dpram ADDR_WIDTH
//  DATA_WIDTH      8   RAM data width; matches dpram DATA_WIDTH
//  CLEAR_ON_RESET  1   1: zero-fill the RAM after reset; 0: skip the fill
// PORTS
//  clock        in   1   single clock, also drives the dpram port
//  reset        in   1   synchronous, active-high
//  req0/req1    in   1   access request; held high until gnt seen
//  we0/we1      in   1   1 = write, 0 = read; held stable with req
//  addr0/addr1  in   AW  word address; held stable with req
//  wdata0/1     in   DW  write data; held stable with req
//  gnt0/gnt1    out  1   combinational; the access issues this cycle
//  rvalid0/1    out  1   one-cycle pulse; rdataN holds the read result
//  rdata0/1     out  DW  registered read data; holds last read value
//  busy         out  1   high while CLEAR runs; requests are ignored
//  ram_address  out  AW  to dpram address_x
//  ram_data     out  DW  to dpram data_x
//  ram_wren     out  1   to dpram wren_x
//  ram_q        in   DW  from dpram q_x; valid the cycle after the address
// BEHAVIOUR
//  Reset values: gnt=0, rvalid=0, rdata=0, busy=CLEAR_ON_RESET, ram_wren=0.
//  Internal state is also reset: rr_last=1, so req0 wins the first contest.
//  States: CLEAR -> ARB. Reset enters CLEAR if CLEAR_ON_RESET=1, else ARB.
//  CLEAR: clr_cnt counts 0..2^AW-1 at one word per cycle.
//   - ram_address=clr_cnt, ram_data=0, ram_wren=1, gnt0/gnt1=0.
//   - Moves to ARB the cycle after clr_cnt=all-ones; busy falls with it.
//   - Total length is 2^AW cycles.
//  ARB, per cycle:
//   - Only req0: gnt0. Only req1: gnt1.
//   - Both: grant !rr_last. rr_last updates on every grant.
//   - Neither: ram_wren=0; ram_address/ram_data hold their previous values.
//  Granted access drives ram_address/ram_data/ram_wren from the winner, same
//  cycle, combinationally.
//  Read granted in cycle T:
//   - ram_q is valid in T+1.
//   - rdataN<=ram_q and rvalidN=1 are registered at the end of T+1, so they
//     are visible in T+2. Latency is 2 cycles from gnt to rvalid.
//  Write: no rvalid; its ram_q echo is ignored.
//  Throughput: one access per cycle, back-to-back. A read pipeline tag
//  (valid+id), 2 stages deep, steers each rvalid.
//  Requester holding req across cycles: after its grant it is a new request.
//  Read-after-write, same address, consecutive cycles: the read returns the
//  new data (the RAM is write-first and the write lands first).
//  reset mid-operation:
//   - Pipeline tags cleared; no rvalid is produced for in-flight reads.
//   - The CLEAR sequence restarts from address 0.
//  Inputs are don't-care while req=0. No errors or timeouts.
// STRUCTURE
//  Package dpram_arb_pkg holds:
//   - state encoding ST_CLEAR/ST_ARB
//   - requester ids REQ_0=1'b0/REQ_1=1'b1
//   - read-tag struct {valid,id}
//  Sub-module rr_arb2 takes req[1:0] and rr_last and returns gnt[1:0]. It
//  is combinational; the parent owns the pointer register.
//  The top holds the FSM, clr_cnt, output mux and read-tag pipeline.
// TESTING
//  Use AW=4 for fast CLEAR; bench has a behavioural dpram model.
//  1 Reset, wait: busy high 16 cycles, 16 zero writes to addr 0..15, then
//    busy=0. A read of addr 7 returns 0.
//  2 req0 we0=1 addr3 wdata=A5, then read addr3: gnt0 in T.
//    rvalid0 and rdata0=A5 in T+2; rvalid1 stays 0.
//  3 req0,req1 held reads for 4 cycles: grants alternate 0,1,0,1.
//    rvalids follow 2 cycles later with matching ids and data.
//  4 Write addr5=3C via port1, read addr5 via port0 next cycle: rdata0=3C.
//  5 Read issued, reset asserted at T+1: no rvalid.
//    CLEAR restarts at addr 0 and gnt stays low throughout.
//  6 CLEAR_ON_RESET=0: busy=0 after reset. A req0 read in the first cycle
//    after reset is granted immediately.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared types for the dpram port arbiter: FSM states, requester ids, read tag.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package dpram_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  // Travels alongside an issued read so its result reaches the right requester
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the one not served last.
// Latency: combinational, zero cycles.
// Backpressure: a losing request simply sees no grant and stays pending.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] gnt
);

  // Pick the winner; on a tie the requester that did not win last time goes first
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one dpram port between two requesters and zero-fills the RAM after reset.
// Latency: grant same cycle, read data and rvalid two cycles after the grant.
// Backpressure: requests wait (no grant) while the other side wins or while the clear runs.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  rr_last;
  rd_tag_t               tag_s1;
  rd_tag_t               tag_s2;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [1:0]            arb_gnt;
  logic                  arb_en;

  rr_arb2 u_rr_arb2 (
    .req     ({req1, req0}),
    .rr_last (rr_last),
    .gnt     (arb_gnt)
  );

  // Grants only exist in ARB and never in a reset cycle
  assign arb_en = (state == ST_ARB) && !reset;
  assign gnt0   = arb_en && arb_gnt[0];
  assign gnt1   = arb_en && arb_gnt[1];

  // Read results come out of the second tag stage, one cycle after ram_q was captured
  assign rvalid0 = tag_s2.valid && (tag_s2.id == REQ_0);
  assign rvalid1 = tag_s2.valid && (tag_s2.id == REQ_1);

  // Drive the RAM pins: clear writes, then the winner, else hold address/data idle
  always_comb begin
    ram_address = hold_addr;
    ram_data    = hold_data;
    ram_wren    = 1'b0;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        ram_address = clr_cnt;
        ram_data    = '0;
        ram_wren    = 1'b1;
      end else if (gnt0) begin
        ram_address = addr0;
        ram_data    = wdata0;
        ram_wren    = we0;
      end else if (gnt1) begin
        ram_address = addr1;
        ram_data    = wdata1;
        ram_wren    = we1;
      end
    end
  end

  // Clear sequencer: one zero write per cycle, then hand over to arbitration
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
      busy    <= CLEAR_ON_RESET;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == CLR_LAST) begin
        state <= ST_ARB;
        busy  <= 1'b0;
      end
    end
  end

  // Remember who won last and what was last put on the RAM pins
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last   <= 1'b1;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        rr_last <= gnt1;
      end
      hold_addr <= ram_address;
      hold_data <= ram_data;
    end
  end

  // Read tag pipeline and result capture; writes never enter the pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      tag_s1.valid <= (gnt0 && !we0) || (gnt1 && !we1);
      tag_s1.id    <= gnt1 ? REQ_1 : REQ_0;
      tag_s2       <= tag_s1;
      if (tag_s1.valid) begin
        if (tag_s1.id == REQ_0) begin
          rdata0 <= ram_q;
        end else begin
          rdata1 <= ram_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter with behavioural write-first RAMs and a scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_dpram_port_arbiter;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic preload;

  // instance A: clears after reset
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
  logic [DW-1:0] rdata0, rdata1, ram_data, ram_q;
  logic [AW-1:0] ram_address;

  // instance B: no clear
  logic          b_req0, b_req1, b_we0, b_we1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_wdata0, b_wdata1;
  logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy, b_ram_wren;
  logic [DW-1:0] b_rdata0, b_rdata1, b_ram_data, b_ram_q;
  logic [AW-1:0] b_ram_address;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  int checks = 0;
  int errors = 0;

  // expected RAM contents and round-robin history, at the level of the rules
  logic [DW-1:0] exp_mem [DEPTH];
  int            last_win;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rd_exp_t;
  rd_exp_t rq[$];

  dpram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  dpram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .busy(b_busy),
    .ram_address(b_ram_address), .ram_data(b_ram_data), .ram_wren(b_ram_wren), .ram_q(b_ram_q)
  );

  // write-first single-port RAM models; preload fills them with non-zero junk
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= 8'hEE;
        mem_b[i] <= 8'(8'h40 + i);
      end
    end else begin
      if (ram_wren) begin
        mem_a[ram_address] <= ram_data;
        ram_q <= ram_data;
      end else begin
        ram_q <= mem_a[ram_address];
      end
      if (b_ram_wren) begin
        mem_b[b_ram_address] <= b_ram_data;
        b_ram_q <= b_ram_data;
      end else begin
        b_ram_q <= mem_b[b_ram_address];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0; b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
  endtask

  // Test 1: reset values, 16-cycle clear, then a read of addr 7 returns 0
  task automatic test_reset();
    idle_inputs();
    preload = 1;
    reset   = 1;
    req0    = 1;
    next_cycle();
    preload = 0;
    @(negedge clock);
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_wren !== 1'b0) begin
      errors++; $display("FAIL reset_gnt_wren: gnt0=%b gnt1=%b wren=%b, want 0 0 0", gnt0, gnt1, ram_wren);
    end
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 8'h00 || rdata1 !== 8'h00 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_outputs: rv=%b%b rd0=%h rd1=%h busy=%b, want 00 00 00 1",
                         rvalid0, rvalid1, rdata0, rdata1, busy);
    end
    next_cycle();
    reset = 0;
    req0  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b1 || ram_wren !== 1'b1 || ram_address !== AW'(i) || ram_data !== 8'h00 || gnt0 !== 1'b0) begin
        errors++; $display("FAIL clear_step%0d: busy=%b wren=%b addr=%0d data=%h gnt0=%b, want 1 1 %0d 00 0",
                           i, busy, ram_wren, ram_address, ram_data, gnt0, i);
      end
      next_cycle();
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || ram_wren !== 1'b0) begin
      errors++; $display("FAIL clear_done: busy=%b wren=%b, want 0 0", busy, ram_wren);
    end
    begin
      int nz = 0;
      for (int i = 0; i < DEPTH; i++) if (mem_a[i] !== 8'h00) nz++;
      checks++;
      if (nz != 0) begin
        errors++; $display("FAIL clear_contents: %0d nonzero words, want 0", nz);
      end
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
    last_win = 1;
    // read addr 7
    req0 = 1; we0 = 0; addr0 = 4'd7;
    @(negedge clock);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL read7_gnt: gnt0=%b gnt1=%b, want 1 0", gnt0, gnt1);
    end
    next_cycle();
    req0 = 0;
    next_cycle();
    @(negedge clock);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h00 || rvalid1 !== 1'b0) begin
      errors++; $display("FAIL read7_data: rv0=%b rd0=%h rv1=%b, want 1 00 0", rvalid0, rdata0, rvalid1);
    end
    last_win = 0;
    next_cycle();
  endtask

  // Test 2: write A5 to addr 3 via port 0, then read it back
  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 8'hA5;
    @(negedge clock);
    checks++;
    if (gnt0 !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 4'd3 || ram_data !== 8'hA5) begin
      errors++; $display("FAIL wr3_issue: gnt0=%b wren=%b addr=%0d data=%h, want 1 1 3 a5",
                         gnt0, ram_wren, ram_address, ram_data);
    end
    next_cycle();
    we0 = 0;
    @(negedge clock);
    checks++;
    if (gnt0 !== 1'b1 || ram_wren !== 1'b0 || ram_address !== 4'd3) begin
      errors++; $display("FAIL rd3_issue: gnt0=%b wren=%b addr=%0d, want 1 0 3", gnt0, ram_wren, ram_address);
    end
    next_cycle();
    req0 = 0;
    @(negedge clock);
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      errors++; $display("FAIL rd3_early: rv0=%b rv1=%b, want 0 0 (write gives no rvalid)", rvalid0, rvalid1);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5 || rvalid1 !== 1'b0) begin
      errors++; $display("FAIL rd3_data: rv0=%b rd0=%h rv1=%b, want 1 a5 0", rvalid0, rdata0, rvalid1);
    end
    exp_mem[3] = 8'hA5;
    next_cycle();
  endtask

  // Test 3: both requesters hold reads for 4 cycles; grants alternate 0,1,0,1
  task automatic test_alternate();
    // port 1 write first so port 0 wins the first contest
    req1 = 1; we1 = 1; addr1 = 4'd9; wdata1 = 8'h5A;
    @(negedge clock);
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL alt_prime: gnt1=%b gnt0=%b, want 1 0", gnt1, gnt0);
    end
    exp_mem[9] = 8'h5A;
    next_cycle();
    req0 = 1; we0 = 0; addr0 = 4'd3;
    req1 = 1; we1 = 0; addr1 = 4'd9;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k < 4) begin
        checks++;
        if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin
          errors++; $display("FAIL alt_gnt%0d: gnt0=%b gnt1=%b, want %0d %0d", k, gnt0, gnt1, k % 2 == 0, k % 2 == 1);
        end
      end
      if (k >= 2) begin
        checks++;
        if ((k % 2 == 0) ? (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== 8'hA5)
                         : (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== 8'h5A)) begin
          errors++; $display("FAIL alt_rv%0d: rv0=%b rv1=%b rd0=%h rd1=%h, want port%0d valid (a5/5a)",
                             k, rvalid0, rvalid1, rdata0, rdata1, k % 2);
        end
      end
      next_cycle();
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
    end
    last_win = 1;
  endtask

  // Test 4: port 1 writes 3C to addr 5, port 0 reads addr 5 the next cycle
  task automatic test_raw();
    req1 = 1; we1 = 1; addr1 = 4'd5; wdata1 = 8'h3C;
    @(negedge clock);
    checks++;
    if (gnt1 !== 1'b1 || ram_wren !== 1'b1) begin
      errors++; $display("FAIL raw_wr: gnt1=%b wren=%b, want 1 1", gnt1, ram_wren);
    end
    next_cycle();
    req1 = 0;
    req0 = 1; we0 = 0; addr0 = 4'd5;
    @(negedge clock);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL raw_rd_gnt: gnt0=%b, want 1", gnt0);
    end
    next_cycle();
    req0 = 0;
    next_cycle();
    @(negedge clock);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h3C) begin
      errors++; $display("FAIL raw_data: rv0=%b rd0=%h, want 1 3c", rvalid0, rdata0);
    end
    exp_mem[5] = 8'h3C;
    last_win = 0;
    next_cycle();
  endtask

  // Random traffic against the scoreboard
  task automatic test_random();
    bit            act [2];
    bit            pwe [2];
    logic [AW-1:0] pad [2];
    logic [DW-1:0] pdt [2];
    int            win;
    bit            e0, e1;
    for (int i = 0; i < 2; i++) act[i] = 0;
    rq.delete();
    for (int c = 0; c < 303; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i]) begin
          act[i] = (c < 300) && ($urandom_range(0, 2) != 0);
          pwe[i] = 1'($urandom_range(0, 1));
          pad[i] = AW'($urandom_range(0, DEPTH - 1));
          pdt[i] = DW'($urandom);
        end
      end
      req0 = act[0]; we0 = pwe[0]; addr0 = pad[0]; wdata0 = pdt[0];
      req1 = act[1]; we1 = pwe[1]; addr1 = pad[1]; wdata1 = pdt[1];
      @(negedge clock);
      if (act[0] && act[1]) win = (last_win == 1) ? 0 : 1;
      else if (act[0])      win = 0;
      else if (act[1])      win = 1;
      else                  win = -1;
      checks++;
      if (gnt0 !== (win == 0) || gnt1 !== (win == 1)) begin
        errors++; $display("FAIL rnd_gnt c=%0d: gnt0=%b gnt1=%b, want winner %0d", c, gnt0, gnt1, win);
      end
      e0 = 0; e1 = 0;
      if (rq.size() > 0 && rq[0].due == c) begin
        e0 = (rq[0].id == 0);
        e1 = (rq[0].id == 1);
      end
      checks++;
      if (rvalid0 !== e0 || rvalid1 !== e1) begin
        errors++; $display("FAIL rnd_rvalid c=%0d: rv0=%b rv1=%b, want %b %b", c, rvalid0, rvalid1, e0, e1);
      end
      if (e0 || e1) begin
        checks++;
        if ((e0 ? rdata0 : rdata1) !== rq[0].data) begin
          errors++; $display("FAIL rnd_rdata c=%0d port%0d: got %h, want %h", c, rq[0].id, e0 ? rdata0 : rdata1, rq[0].data);
        end
        void'(rq.pop_front());
      end
      if (win >= 0) begin
        if (pwe[win]) exp_mem[pad[win]] = pdt[win];
        else rq.push_back('{due: c + 2, id: win, data: exp_mem[pad[win]]});
        last_win = win;
        act[win] = 0;
      end
      next_cycle();
    end
    req0 = 0; req1 = 0;
    checks++;
    if (rq.size() != 0) begin
      errors++; $display("FAIL rnd_drain: %0d reads without rvalid, want 0", rq.size());
    end
  endtask

  // Test 5: reset lands one cycle after a read; no rvalid, clear restarts, no grants
  task automatic test_reset_midop();
    req0 = 1; we0 = 0; addr0 = 4'd3;
    @(negedge clock);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL mid_issue: gnt0=%b, want 1", gnt0);
    end
    next_cycle();
    req0 = 0; req1 = 1; we1 = 0; addr1 = 4'd1;
    reset = 1;
    @(negedge clock);
    checks++;
    if (gnt1 !== 1'b0 || ram_wren !== 1'b0) begin
      errors++; $display("FAIL mid_rst_gnt: gnt1=%b wren=%b, want 0 0", gnt1, ram_wren);
    end
    next_cycle();
    reset = 0;
    req0 = 1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      checks++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 ||
          busy !== 1'b1 || ram_wren !== 1'b1 || ram_address !== AW'(i)) begin
        errors++; $display("FAIL mid_clear%0d: rv=%b%b gnt=%b%b busy=%b wren=%b addr=%0d, want 00 00 1 1 %0d",
                           i, rvalid0, rvalid1, gnt0, gnt1, busy, ram_wren, ram_address, i);
      end
      next_cycle();
    end
    req1 = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || gnt0 !== 1'b1) begin
      errors++; $display("FAIL mid_after: busy=%b gnt0=%b, want 0 1", busy, gnt0);
    end
    next_cycle();
    req0 = 0;
    next_cycle();
    @(negedge clock);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h00) begin
      errors++; $display("FAIL mid_reread: rv0=%b rd0=%h, want 1 00", rvalid0, rdata0);
    end
    next_cycle();
  endtask

  // Test 6: without the clear, a read right after reset is granted at once
  task automatic test_no_clear();
    reset = 1;
    next_cycle();
    reset = 0;
    b_req0 = 1; b_we0 = 0; b_addr0 = 4'd2;
    @(negedge clock);
    checks++;
    if (b_busy !== 1'b0 || b_gnt0 !== 1'b1 || b_ram_wren !== 1'b0 || b_ram_address !== 4'd2) begin
      errors++; $display("FAIL nc_grant: busy=%b gnt0=%b wren=%b addr=%0d, want 0 1 0 2",
                         b_busy, b_gnt0, b_ram_wren, b_ram_address);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL nc_other_busy: busy=%b, want 1", busy);
    end
    next_cycle();
    b_req0 = 0;
    next_cycle();
    @(negedge clock);
    checks++;
    if (b_rvalid0 !== 1'b1 || b_rdata0 !== 8'h42 || b_rvalid1 !== 1'b0) begin
      errors++; $display("FAIL nc_data: rv0=%b rd0=%h rv1=%b, want 1 42 0", b_rvalid0, b_rdata0, b_rvalid1);
    end
    next_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    last_win = 1;
    test_reset();
    test_write_read();
    test_alternate();
    test_raw();
    test_random();
    test_reset_midop();
    test_no_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
